decoder_hakem: RTL and testbench
================================

DECODER_HAKEM -- requirements
Module: decoder_hakem

Interface
REQ-001 The block SHALL have parameter N, default 12, meaning word width shared with the decoder.
REQ-002 The block SHALL have parameter K, default 4, meaning number of requesters.
REQ-003 The block SHALL have parameter PARCA, default 3, meaning serial chunk width; N SHALL be divisible by PARCA.
REQ-004 The block SHALL have parameter ZAMAN_ASIMI, default 64, meaning BEKLE timeout in cycles; it is used only under the configuration macro.
REQ-005 The block SHALL have ports as follows: clk  in  1  clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 istek  in  K  per-requester request, held until kabul.
REQ-008 istek_mod  in  K  per-requester mode: 0 = parallel, 1 = serial.
REQ-009 istek_veri  in  K*N  per-requester word; requester i uses slice [i*N +: N].
REQ-010 kabul  out  K  one-hot, 1-cycle acceptance pulse.
REQ-011 sonuc  out  N  result word.
REQ-012 sonuc_gecerli  out  K  one-hot, 1-cycle result-valid pulse.
REQ-013 hata  out  1  timeout flag, qualified by sonuc_gecerli.
REQ-014 mesgul  out  1  high whenever the state is not BOS.
REQ-015 d_basla  out  1  decoder start.
REQ-016 d_mod  out  1  decoder mode.
REQ-017 d_gelen_veri  out  N  decoder input data.
REQ-018 d_cikan_veri  in  N  decoder result.
REQ-019 d_bitti  in  1  decoder done.

Function
REQ-020 The FSM SHALL have states BOS, GONDER, BEKLE and TESLIM.
REQ-021 In BOS with any istek bit high at edge t, the block SHALL pick a winner round-robin, starting at the requester after the last winner.
REQ-022 At t+1 the block SHALL assert kabul[winner], capture the winner's mod and word, and enter GONDER.
REQ-023 In GONDER with mod 0, the block SHALL drive d_basla=1, d_mod=0 and d_gelen_veri = the full word for exactly 1 cycle.
REQ-024 In GONDER with mod 1, the block SHALL drive d_basla=1 and d_mod=1 for N/PARCA consecutive cycles, with d_gelen_veri[PARCA-1:0] = the word's chunks MSB-first and the upper bits 0.
REQ-025 After the last GONDER cycle, the block SHALL enter BEKLE and drive d_basla=0.
REQ-026 In BEKLE, the block SHALL ignore d_bitti during GONDER; on the first d_bitti=1 it SHALL capture d_cikan_veri and enter TESLIM.
REQ-027 In TESLIM (1 cycle), the block SHALL drive sonuc = the captured word, sonuc_gecerli[winner]=1 and hata=0, then enter BOS.
REQ-028 In BOS, the block SHALL be able to re-arbitrate in the cycle right after TESLIM.
REQ-029 Minimum latency from istek to sonuc_gecerli SHALL be 3 cycles plus decoder latency for mod 0, and 3+N/PARCA-1 plus decoder latency for mod 1.
REQ-030 Simultaneous requests SHALL be granted one per transaction in round-robin order; losers SHALL keep istek high and the block SHALL lose no request.
REQ-031 Dropping istek before kabul SHALL be legal and SHALL have no effect.
REQ-032 istek changes after kabul SHALL be ignored until TESLIM.
REQ-033 sonuc SHALL hold its value between pulses.
REQ-034 All other outputs SHALL be 0 outside the states that drive them.

Reset
REQ-035 While rst=0, the block SHALL immediately force: all outputs 0, state BOS, round-robin pointer K-1 (so requester 0 has first priority), chunk counter 0.
REQ-036 A reset during GONDER or BEKLE SHALL abort the transaction without a sonuc_gecerli pulse; the requester must re-request.

Configuration
REQ-037 The macro DECODER_HAKEM_TIMEOUT_EN SHALL select the timeout behaviour.
REQ-038 When DECODER_HAKEM_TIMEOUT_EN is defined, a counter SHALL run in BEKLE; at ZAMAN_ASIMI cycles without d_bitti, the block SHALL enter TESLIM with sonuc=0 and hata=1.
REQ-039 When DECODER_HAKEM_TIMEOUT_EN is undefined, the block SHALL have no counter, hata SHALL be tied to 0, and BEKLE SHALL wait indefinitely.

Structure
REQ-040 Package decoder_hakem_pkg SHALL hold the state enum (BOS, GONDER, BEKLE, TESLIM) and the default constants for N, PARCA and ZAMAN_ASIMI.
REQ-041 The block SHALL contain one sub-module, rr_hakem: a K-way round-robin arbiter with inputs istek and pointer, and a one-hot grant output.

Verification
REQ-042 The bench SHALL cover: requester 0, mod 0, word 011100010110 -> d_basla for 1 cycle with that word; decoder returns 010001110100 -> sonuc_gecerli=0001 and sonuc=010001110100.
REQ-043 The bench SHALL cover: requester 1, mod 1, word 111101110000 -> d_gelen_veri[2:0] = 111, 101, 110, 000 on 4 consecutive d_basla cycles.
REQ-044 The bench SHALL cover: all 4 requesters held high -> kabul order 0001, 0010, 0100, 1000, 0001.
REQ-045 The bench SHALL cover: requesters 0 and 2 high from reset -> 0 granted first, then 2, with no gap beyond TESLIM.
REQ-046 The bench SHALL cover: rst low in BEKLE -> all outputs 0 at once, no sonuc_gecerli; the next request is served normally.
REQ-047 The bench SHALL cover, with DECODER_HAKEM_TIMEOUT_EN: d_bitti stuck at 0 -> hata=1 with sonuc_gecerli 64 cycles after BEKLE entry; without the macro -> mesgul stays 1.

Source files
------------

// File: rtl/decoder_hakem_pkg.sv
// Shared definitions for decoder_hakem: FSM state encoding, default sizes and a
// helper for counter widths.
package decoder_hakem_pkg;

  localparam int unsigned N_VARSAYILAN           = 12;
  localparam int unsigned K_VARSAYILAN           = 4;
  localparam int unsigned PARCA_VARSAYILAN       = 3;
  localparam int unsigned ZAMAN_ASIMI_VARSAYILAN = 64;

  // FSM state encoding
  typedef logic [1:0] durum_t;
  localparam durum_t BOS    = 2'd0;
  localparam durum_t GONDER = 2'd1;
  localparam durum_t BEKLE  = 2'd2;
  localparam durum_t TESLIM = 2'd3;

  // Bits needed to count 0..deger-1, never less than one.
  function automatic int unsigned sayac_genislik(input int unsigned deger);
    return (deger > 1) ? $clog2(deger) : 1;
  endfunction

endpackage

// File: rtl/decoder_hakem_rr.sv
// rr_hakem: K-way round-robin arbiter. The requester right after isaretci has
// the highest priority; verilen is one-hot, or all zero when nobody requests.
module rr_hakem #(
  parameter int unsigned K  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [K-1:0]  istek,
  input  logic [PW-1:0] isaretci,
  output logic [K-1:0]  verilen
);

  int en_yakin;

  // Grant the requester with the smallest distance from isaretci+1.
  always_comb begin
    en_yakin = int'(K);
    for (int j = 0; j < int'(K); j++) begin
      if (istek[j] && ((j + int'(K) - 1 - int'(isaretci)) % int'(K)) < en_yakin) begin
        en_yakin = (j + int'(K) - 1 - int'(isaretci)) % int'(K);
      end
    end
    verilen = '0;
    for (int j = 0; j < int'(K); j++) begin
      verilen[j] = istek[j] && (((j + int'(K) - 1 - int'(isaretci)) % int'(K)) == en_yakin);
    end
  end

endmodule

// File: rtl/decoder_hakem.sv
// decoder_hakem: shares one decoder between K requesters. A round-robin winner's
// word is sent in parallel or as PARCA-bit chunks (MSB first), the decoder result
// is captured and returned with a one-hot valid pulse.
// Optional macro DECODER_HAKEM_TIMEOUT_EN: abandon BEKLE after ZAMAN_ASIMI cycles
// and report hata=1 with sonuc=0.
module decoder_hakem
  import decoder_hakem_pkg::*;
#(
  parameter int unsigned N           = N_VARSAYILAN,
  parameter int unsigned K           = K_VARSAYILAN,
  parameter int unsigned PARCA       = PARCA_VARSAYILAN,
  parameter int unsigned ZAMAN_ASIMI = ZAMAN_ASIMI_VARSAYILAN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [K-1:0]   istek,
  input  logic [K-1:0]   istek_mod,
  input  logic [K*N-1:0] istek_veri,
  output logic [K-1:0]   kabul,
  output logic [N-1:0]   sonuc,
  output logic [K-1:0]   sonuc_gecerli,
  output logic           hata,
  output logic           mesgul,
  output logic           d_basla,
  output logic           d_mod,
  output logic [N-1:0]   d_gelen_veri,
  input  logic [N-1:0]   d_cikan_veri,
  input  logic           d_bitti
);

  localparam int unsigned PARCA_SAYISI = N / PARCA;
  localparam int unsigned SW           = sayac_genislik(PARCA_SAYISI);
  localparam int unsigned PW           = sayac_genislik(K);

  durum_t         durum_q, durum_d;
  logic [PW-1:0]  isaretci_q, isaretci_d;
  logic [K-1:0]   kazanan_q, kazanan_d;
  logic           mod_q, mod_d;
  logic [N-1:0]   veri_q, veri_d;
  logic [SW-1:0]  sayac_q, sayac_d;
  logic [N-1:0]   sonuc_q, sonuc_d;
  logic [K-1:0]   kabul_q, kabul_d;

  logic [K-1:0]   verilen;
  logic [PW-1:0]  secilen_idx;
  logic           secilen_mod;
  logic [N-1:0]   secilen_veri;
  logic [N-1:0]   parca_genis;

`ifdef DECODER_HAKEM_TIMEOUT_EN
  localparam int unsigned ZW = sayac_genislik(ZAMAN_ASIMI);
  logic [ZW-1:0]  zaman_q, zaman_d;
  logic           hata_q, hata_d;
`else
  // ZAMAN_ASIMI has no effect when the timeout is compiled out.
  if (ZAMAN_ASIMI == 0) begin : g_zaman_kullanilmiyor
  end
`endif

  rr_hakem #(
    .K  (K),
    .PW (PW)
  ) u_rr_hakem (
    .istek    (istek),
    .isaretci (isaretci_q),
    .verilen  (verilen)
  );

  // Index, mode and word of the requester the arbiter picked.
  always_comb begin
    secilen_idx  = '0;
    secilen_mod  = 1'b0;
    secilen_veri = '0;
    for (int i = 0; i < int'(K); i++) begin
      if (verilen[i]) begin
        secilen_idx  = PW'(i);
        secilen_mod  = istek_mod[i];
        secilen_veri = istek_veri[i*N +: N];
      end
    end
  end

  // Next-state logic for the arbitration / send / wait / deliver sequence.
  always_comb begin
    durum_d    = durum_q;
    isaretci_d = isaretci_q;
    kazanan_d  = kazanan_q;
    mod_d      = mod_q;
    veri_d     = veri_q;
    sayac_d    = sayac_q;
    sonuc_d    = sonuc_q;
    kabul_d    = '0;
`ifdef DECODER_HAKEM_TIMEOUT_EN
    zaman_d    = '0;
    hata_d     = hata_q;
`endif
    case (durum_q)
      BOS: begin
        if (|istek) begin
          durum_d    = GONDER;
          kabul_d    = verilen;
          kazanan_d  = verilen;
          isaretci_d = secilen_idx;
          mod_d      = secilen_mod;
          veri_d     = secilen_veri;
          sayac_d    = '0;
        end
      end
      GONDER: begin
        if (!mod_q || sayac_q == SW'(PARCA_SAYISI - 1)) begin
          durum_d = BEKLE;
          sayac_d = '0;
        end else begin
          // Serial: next chunk moves into the top PARCA bits.
          sayac_d = sayac_q + SW'(1);
          veri_d  = veri_q << PARCA;
        end
      end
      BEKLE: begin
        if (d_bitti) begin
          durum_d = TESLIM;
          sonuc_d = d_cikan_veri;
`ifdef DECODER_HAKEM_TIMEOUT_EN
          hata_d  = 1'b0;
        end else if (zaman_q == ZW'(ZAMAN_ASIMI - 1)) begin
          durum_d = TESLIM;
          sonuc_d = '0;
          hata_d  = 1'b1;
        end else begin
          zaman_d = zaman_q + ZW'(1);
`endif
        end
      end
      TESLIM: durum_d = BOS;
      default: durum_d = BOS;
    endcase
  end

  // State registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum_q    <= BOS;
      isaretci_q <= PW'(K - 1);
      kazanan_q  <= '0;
      mod_q      <= 1'b0;
      veri_q     <= '0;
      sayac_q    <= '0;
      sonuc_q    <= '0;
      kabul_q    <= '0;
    end else begin
      durum_q    <= durum_d;
      isaretci_q <= isaretci_d;
      kazanan_q  <= kazanan_d;
      mod_q      <= mod_d;
      veri_q     <= veri_d;
      sayac_q    <= sayac_d;
      sonuc_q    <= sonuc_d;
      kabul_q    <= kabul_d;
    end
  end

`ifdef DECODER_HAKEM_TIMEOUT_EN
  // Timeout counter and the error flag that accompanies the result pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zaman_q <= '0;
      hata_q  <= 1'b0;
    end else begin
      zaman_q <= zaman_d;
      hata_q  <= hata_d;
    end
  end
`endif

  // Current serial chunk, zero-extended to the decoder width.
  always_comb begin
    parca_genis              = '0;
    parca_genis[PARCA-1:0]   = veri_q[N-1 -: PARCA];
  end

  // Outputs decoded from the current state; zero outside the states that drive them.
  always_comb begin
    kabul         = kabul_q;
    sonuc         = sonuc_q;
    mesgul        = (durum_q != BOS);
    sonuc_gecerli = '0;
    hata          = 1'b0;
    d_basla       = 1'b0;
    d_mod         = 1'b0;
    d_gelen_veri  = '0;
    if (durum_q == GONDER) begin
      d_basla      = 1'b1;
      d_mod        = mod_q;
      d_gelen_veri = mod_q ? parca_genis : veri_q;
    end
    if (durum_q == TESLIM) begin
      sonuc_gecerli = kazanan_q;
`ifdef DECODER_HAKEM_TIMEOUT_EN
      hata          = hata_q;
`endif
    end
  end

endmodule

// File: tb/tb_decoder_hakem.sv
// Bench for decoder_hakem: a transaction-timeline model predicts every output on
// every cycle; directed scenarios add hand-computed literal expectations.
module tb_decoder_hakem;

  localparam int N  = 12;
  localparam int K  = 4;
  localparam int PARCA = 3;
  localparam int ZA = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [K-1:0]   istek, istek_mod, kabul, sonuc_gecerli;
  logic [K*N-1:0] istek_veri;
  logic [N-1:0]   sonuc, d_gelen_veri, d_cikan_veri;
  logic           hata, mesgul, d_basla, d_mod, d_bitti;

  decoder_hakem #(
    .N           (N),
    .K           (K),
    .PARCA       (PARCA),
    .ZAMAN_ASIMI (ZA)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .istek         (istek),
    .istek_mod     (istek_mod),
    .istek_veri    (istek_veri),
    .kabul         (kabul),
    .sonuc         (sonuc),
    .sonuc_gecerli (sonuc_gecerli),
    .hata          (hata),
    .mesgul        (mesgul),
    .d_basla       (d_basla),
    .d_mod         (d_mod),
    .d_gelen_veri  (d_gelen_veri),
    .d_cikan_veri  (d_cikan_veri),
    .d_bitti       (d_bitti)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: one transaction at a time, described by its offset m_t from kabul.
  bit         m_busy;
  int         m_t, m_win, m_rr, m_L, m_D;
  bit         m_mod;
  logic [N-1:0] m_word, m_R, m_sonuc;

  bit         auto_drop = 1'b1;
  bit         fix_on    = 1'b0;
  int         fix_D;
  logic [N-1:0] fix_R;

  logic [N-1:0] basla_log[$];
  logic [K-1:0] kabul_log[$];
  logic [K-1:0] gecerli_log[$];
  logic [N-1:0] sonuc_log[$];
  bit           hata_log[$];
  int           kabul_cyc[$];
  int           gecerli_cyc[$];
  int           last_basla_cyc;

  task automatic check(input string nm, input logic [31:0] gercek, input logic [31:0] beklenen);
    total++;
    if (gercek !== beklenen) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, gercek, beklenen);
    end
  endtask

  function automatic logic [N-1:0] parca(input logic [N-1:0] w, input int c);
    logic [N-1:0] s;
    s = w >> (N - PARCA * (c + 1));
    return s & N'((1 << PARCA) - 1);
  endfunction

  // Offset of the result cycle: L send cycles, D+1 wait cycles (capped by timeout).
  function automatic int teslim_t();
`ifdef DECODER_HAKEM_TIMEOUT_EN
    return m_L + (((m_D + 1) < ZA) ? (m_D + 1) : ZA);
`else
    return m_L + m_D + 1;
`endif
  endfunction

  function automatic bit zaman_asti();
`ifdef DECODER_HAKEM_TIMEOUT_EN
    return (m_D + 1) > ZA;
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear_logs();
    basla_log.delete(); kabul_log.delete(); gecerli_log.delete();
    sonuc_log.delete(); hata_log.delete(); kabul_cyc.delete(); gecerli_cyc.delete();
  endtask

  // Compare this cycle, play requester/decoder roles, advance the model, clock.
  task automatic step();
    logic [K-1:0] e_kabul, e_gec;
    logic         e_hata, e_basla, e_mod, e_mesgul;
    logic [N-1:0] e_veri;
    int           tt, w;
    bit           bulundu;
    e_kabul = '0; e_gec = '0; e_hata = 1'b0; e_basla = 1'b0; e_mod = 1'b0;
    e_veri = '0; e_mesgul = m_busy; tt = 0;
    if (m_busy) begin
      tt = teslim_t();
      if (m_t == tt) begin
        m_sonuc = zaman_asti() ? '0 : m_R;
        e_gec   = K'(1) << m_win;
        e_hata  = zaman_asti();
      end else if (m_t < m_L) begin
        e_basla = 1'b1;
        e_mod   = m_mod;
        e_veri  = m_mod ? parca(m_word, m_t) : m_word;
        if (m_t == 0) e_kabul = K'(1) << m_win;
      end
    end
    check("kabul", 32'(kabul), 32'(e_kabul));
    check("sonuc", 32'(sonuc), 32'(m_sonuc));
    check("sonuc_gecerli", 32'(sonuc_gecerli), 32'(e_gec));
    check("hata", 32'(hata), 32'(e_hata));
    check("mesgul", 32'(mesgul), 32'(e_mesgul));
    check("d_basla", 32'(d_basla), 32'(e_basla));
    check("d_mod", 32'(d_mod), 32'(e_mod));
    check("d_gelen_veri", 32'(d_gelen_veri), 32'(e_veri));
    if (kabul != '0) begin kabul_log.push_back(kabul); kabul_cyc.push_back(cyc); end
    if (d_basla) begin basla_log.push_back(d_gelen_veri); last_basla_cyc = cyc; end
    if (sonuc_gecerli != '0) begin
      gecerli_log.push_back(sonuc_gecerli); sonuc_log.push_back(sonuc);
      hata_log.push_back(hata); gecerli_cyc.push_back(cyc);
    end
    // Requester lets go once it has seen its kabul.
    if (auto_drop && m_busy && m_t == 0) istek[m_win] = 1'b0;
    // Decoder: answers exactly at its chosen delay inside the wait window, noise elsewhere.
    d_cikan_veri = N'($urandom);
    if (m_busy && m_t >= m_L && m_t < tt) begin
      d_bitti = (m_t == m_L + m_D);
      if (d_bitti) d_cikan_veri = m_R;
    end else begin
      d_bitti = 1'($urandom);
    end
    if (m_busy) begin
      if (m_t == tt) m_busy = 1'b0;
      else m_t++;
    end else if (istek != '0) begin
      bulundu = 1'b0; w = 0;
      for (int i = 1; i <= K; i++) begin
        if (!bulundu && istek[(m_rr + i) % K]) begin
          bulundu = 1'b1; w = (m_rr + i) % K;
        end
      end
      m_win = w; m_rr = w; m_busy = 1'b1; m_t = 0;
      m_mod  = istek_mod[w];
      m_word = istek_veri[w*N +: N];
      m_L    = m_mod ? N / PARCA : 1;
      if (fix_on) begin
        m_D = fix_D; m_R = fix_R;
      end else begin
        m_D = ($urandom % 16 == 0) ? int'($urandom_range(0, 80)) : int'($urandom_range(0, 5));
        m_R = N'($urandom);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int maxc);
    int n;
    n = 0;
    while (m_busy && n < maxc) begin
      step();
      n++;
    end
    check("tx_complete", 32'(m_busy), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_kabul", 32'(kabul), 32'(0));
    check("rst_sonuc", 32'(sonuc), 32'(0));
    check("rst_sonuc_gecerli", 32'(sonuc_gecerli), 32'(0));
    check("rst_hata", 32'(hata), 32'(0));
    check("rst_mesgul", 32'(mesgul), 32'(0));
    check("rst_d_basla", 32'(d_basla), 32'(0));
    check("rst_d_mod", 32'(d_mod), 32'(0));
    check("rst_d_gelen_veri", 32'(d_gelen_veri), 32'(0));
    istek = '0;
    m_busy = 1'b0; m_rr = K - 1; m_sonuc = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc += 2;
  endtask

  initial begin
    int t0, n;
    rst = 1'b1; istek = '0; istek_mod = '0; istek_veri = '0;
    d_bitti = 1'b0; d_cikan_veri = '0;
    m_busy = 1'b0; m_rr = K - 1; m_sonuc = '0; last_basla_cyc = 0;
    #2;
    do_reset();

    // Requester 0, parallel word.
    clear_logs();
    fix_on = 1'b1; fix_D = 2; fix_R = 12'b010001110100;
    istek_mod[0] = 1'b0; istek_veri[0 +: N] = 12'b011100010110; istek = 4'b0001;
    t0 = cyc;
    step();
    run_until_idle(50);
    check("A_basla_count", 32'(basla_log.size()), 32'(1));
    check("A_basla_word", 32'(basla_log[0]), 32'(12'b011100010110));
    check("A_gecerli", 32'(gecerli_log[0]), 32'(4'b0001));
    check("A_sonuc", 32'(sonuc_log[0]), 32'(12'b010001110100));
    check("A_latency", 32'(gecerli_cyc[0] - t0), 32'(5));
    step(); step();
    check("A_sonuc_holds", 32'(sonuc), 32'(12'b010001110100));

    // Requester 1, serial word.
    clear_logs();
    fix_D = 0; fix_R = 12'h3C5;
    istek_mod[1] = 1'b1; istek_veri[N +: N] = 12'b111101110000; istek = 4'b0010;
    t0 = cyc;
    step();
    run_until_idle(50);
    check("B_basla_count", 32'(basla_log.size()), 32'(4));
    check("B_chunk0", 32'(basla_log[0]), 32'(12'b000000000111));
    check("B_chunk1", 32'(basla_log[1]), 32'(12'b000000000101));
    check("B_chunk2", 32'(basla_log[2]), 32'(12'b000000000110));
    check("B_chunk3", 32'(basla_log[3]), 32'(12'b000000000000));
    check("B_gecerli", 32'(gecerli_log[0]), 32'(4'b0010));
    check("B_latency", 32'(gecerli_cyc[0] - t0), 32'(6));

    // All four held high.
    do_reset();
    clear_logs();
    auto_drop = 1'b0; fix_D = 1;
    istek_mod = '0;
    for (int i = 0; i < K; i++) istek_veri[i*N +: N] = N'($urandom);
    istek = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      run_until_idle(50);
    end
    check("C_kabul0", 32'(kabul_log[0]), 32'(4'b0001));
    check("C_kabul1", 32'(kabul_log[1]), 32'(4'b0010));
    check("C_kabul2", 32'(kabul_log[2]), 32'(4'b0100));
    check("C_kabul3", 32'(kabul_log[3]), 32'(4'b1000));
    check("C_kabul4", 32'(kabul_log[4]), 32'(4'b0001));
    istek = '0; auto_drop = 1'b1;

    // Requesters 0 and 2 from reset.
    do_reset();
    clear_logs();
    istek = 4'b0101;
    step(); run_until_idle(50);
    step(); run_until_idle(50);
    check("D_kabul0", 32'(kabul_log[0]), 32'(4'b0001));
    check("D_kabul1", 32'(kabul_log[1]), 32'(4'b0100));
    check("D_gap", 32'(kabul_cyc[1] - gecerli_cyc[0]), 32'(2));

    // Reset while waiting for the decoder.
    clear_logs();
    fix_D = 20; istek_mod[0] = 1'b0; istek_veri[0 +: N] = 12'h123; istek = 4'b0001;
    step();
    n = 0;
    while (m_busy && m_t < m_L + 2 && n < 20) begin step(); n++; end
    check("E_busy_before_rst", 32'(mesgul), 32'(1));
    do_reset();
    check("E_no_pulse", 32'(gecerli_log.size()), 32'(0));
    fix_D = 3; fix_R = 12'hA5C; istek = 4'b0001;
    step(); run_until_idle(50);
    check("E_served_count", 32'(gecerli_log.size()), 32'(1));
    check("E_served_who", 32'(gecerli_log[0]), 32'(4'b0001));
    check("E_served_sonuc", 32'(sonuc_log[0]), 32'(12'hA5C));

    // Decoder never answers.
    clear_logs();
    fix_D = 1000; istek_mod[1] = 1'b0; istek_veri[N +: N] = 12'h777; istek = 4'b0010;
    step();
`ifdef DECODER_HAKEM_TIMEOUT_EN
    run_until_idle(200);
    check("F_hata", 32'(hata_log[0]), 32'(1));
    check("F_gecerli", 32'(gecerli_log[0]), 32'(4'b0010));
    check("F_sonuc", 32'(sonuc_log[0]), 32'(0));
    check("F_timeout_at", 32'(gecerli_cyc[0] - (last_basla_cyc + 1)), 32'(64));
`else
    for (int i = 0; i < 120; i++) step();
    check("F_still_busy", 32'(mesgul), 32'(1));
    check("F_no_pulse", 32'(gecerli_log.size()), 32'(0));
    do_reset();
`endif

    // Randomized traffic with withdrawals and post-kabul data changes.
    do_reset();
    fix_on = 1'b0; auto_drop = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < K; i++) begin
        if (!istek[i]) begin
          istek_mod[i] = 1'($urandom);
          istek_veri[i*N +: N] = N'($urandom);
          if ($urandom % 6 == 0) istek[i] = 1'b1;
        end else if ($urandom % 40 == 0) begin
          istek[i] = 1'b0;
        end
      end
      step();
    end
    istek = '0;
    run_until_idle(200);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
